afifo_rd_packer: RTL

- Read-domain consumer of the 8-bit async FIFO; runs entirely on rclk.
- Pops bytes from the FIFO's first-word-fall-through read port and packs them little-endian into BYTES-wide words.
- Presents each word on a valid/ready master interface to the downstream datapath.
- A flush request emits a partial word with a byte-keep mask and a last marker.

---
 rtl/afifo_rd_packer.sv | 107 ++++++++++
 1 files changed

// File: rtl/afifo_rd_packer.sv
// Read-side packer for the 8-bit async FIFO: pops FWFT bytes on rclk and packs them little-endian
// into BYTES-wide words on a valid/ready master port. A flush emits a keep-masked partial word.
module afifo_rd_packer #(
  parameter int unsigned BYTES = 4,
  parameter int unsigned CW    = 16
) (
  input  logic               rclk,
  input  logic               rstn,
  input  logic               fifo_empty,
  input  logic [7:0]         fifo_data,
  output logic               fifo_rd_en,
  input  logic               flush,
  output logic [8*BYTES-1:0] m_data,
  output logic [BYTES-1:0]   m_keep,
  output logic               m_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CW-1:0]      word_cnt
);

  localparam int unsigned CntW = $clog2(BYTES + 1);

  typedef enum logic [0:0] {StCollect, StHold} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [CntW-1:0]    fill;
  logic [8*BYTES-1:0] acc_q, acc_d;
  logic [BYTES-1:0]   keep_q, keep_d;
  logic               last_q, last_d;
  logic [CW-1:0]      wcnt_q, wcnt_d;
  logic               pop;
  logic               close;

  // rstn gates the pop so nothing leaves the FIFO while reset is held.
  assign fifo_rd_en = rstn && (state_q == StCollect) && !fifo_empty;
  assign pop        = fifo_rd_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    keep_d  = keep_q;
    last_d  = last_q;
    wcnt_d  = wcnt_q;
    fill    = cnt_q + CntW'(pop);
    close   = 1'b0;

    unique case (state_q)
      StCollect: begin
        for (int k = 0; k < int'(BYTES); k++) begin
          if (pop && (CntW'(k) == cnt_q)) begin
            acc_d[8*k +: 8] = fifo_data;
          end
        end
        // Flush closes the word only if it would carry at least one byte.
        close = (pop && (cnt_q == CntW'(BYTES - 1))) || (flush && (fill != '0));
        if (close) begin
          state_d = StHold;
          cnt_d   = '0;
          last_d  = flush;
          for (int k = 0; k < int'(BYTES); k++) begin
            keep_d[k] = (CntW'(k) < fill);
          end
        end else begin
          cnt_d = fill;
        end
      end
      StHold: begin
        if (m_ready) begin
          state_d = StCollect;
          acc_d   = '0;
          keep_d  = '0;
          last_d  = 1'b0;
          wcnt_d  = wcnt_q + CW'(1);
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge rclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StCollect;
      cnt_q   <= '0;
      acc_q   <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Unfilled lanes stay zero because the accumulator is cleared after every handshake.
  assign m_data   = acc_q;
  assign m_keep   = keep_q;
  assign m_last   = last_q;
  assign m_valid  = (state_q == StHold);
  assign word_cnt = wcnt_q;

endmodule
